dsp_mac_sequencer: RTL
======================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 Parameter LEN_W, default 8, width of job length (max job 2^LEN_W-1 operand pairs).
REQ-002 Parameter OPMODE_MAC, default 8'b0000_1001, slice opcode: X=M, Z=P, add, no pre-adder, carry-in 0.
REQ-003 CLK  in  1  single clock; all logic rising-edge.
REQ-004 RST  in  1  asynchronous, active-high reset of all sequencer state.
REQ-005 start  in  1; len  in  LEN_W: job request and pair count, sampled in IDLE only.
REQ-006 busy  out  1: high in every state except IDLE.
REQ-007 in_valid  in  1; in_ready  out  1; in_a, in_b  in  18 each: operand stream.
REQ-008 out_valid  out  1; out_ready  in  1; out_data  out  48: result stream.
REQ-009 dsp_A, dsp_B  out  18; dsp_OPMODE  out  8; dsp_CEA, dsp_CEB, dsp_CEM, dsp_CEP, dsp_CEOPMODE, dsp_RSTM, dsp_RSTP  out  1 each; dsp_P  in  48: slice control and result.

Function
REQ-010 Controlled slice is configured A0REG=B0REG=0, A1REG=B1REG=MREG=PREG=OPMODEREG=1, B_INPUT "DIRECT", RSTTYPE "SYNC"; multiply is unsigned.
REQ-011 States: IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-012 IDLE: start=1 and len!=0 -> latch len into down-counter, go CLEAR; start with len==0 ignored, stay IDLE.
REQ-013 CLEAR lasts exactly one cycle: dsp_RSTM=dsp_RSTP=1; then FEED.
REQ-014 FEED: in_ready=1; a beat is in_valid&&in_ready; per beat dsp_A=in_a, dsp_B=in_b, dsp_CEA=dsp_CEB=1, counter decrements.
REQ-015 dsp_CEA/dsp_CEB SHALL be 0 in any cycle without a beat; in_valid low cycles insert bubbles with no effect on result.
REQ-016 dsp_CEM equals beat delayed 1 cycle; dsp_CEP equals beat delayed 2 cycles (two-stage valid shift register).
REQ-017 Beat with counter==1 is last: next state DRAIN; in_ready low from the following cycle.
REQ-018 DRAIN: wait until valid shift register empty (2 cycles after last beat), then DONE.
REQ-019 DONE: out_valid=1, out_data=dsp_P (stable, CEP=0); out_ready=1 -> IDLE next cycle.
REQ-020 First out_valid cycle is exactly 3 cycles after the last-beat cycle.
REQ-021 out_valid, out_data held unchanged while out_ready=0; start ignored outside IDLE.
REQ-022 dsp_OPMODE=OPMODE_MAC constant; dsp_CEOPMODE=1 always.
REQ-023 Accumulation is modulo 2^48; 255 pairs of 18-bit unsigned operands cannot overflow.
REQ-024 dsp_A/dsp_B are 0 when no beat.

Reset
REQ-025 RST asserted: state IDLE, counter 0, shift register 0 immediately, regardless of clock.
REQ-026 Reset values: busy=0, in_ready=0, out_valid=0, out_data don't-care (gated by out_valid), all dsp_CE*=0 except dsp_CEOPMODE=1, dsp_RSTM=dsp_RSTP=0, dsp_A=dsp_B=0.
REQ-027 Reset mid-job abandons job; stale slice P/M is cleared by CLEAR of next job, never by reset.

Structure
REQ-028 Shared package holds state enumeration, OPMODE_MAC constant, slice latency constants (CEM delay 1, CEP delay 2).
REQ-029 No sub-module required; verification bench instantiates dsp48a1_unit with REQ-010 parameters as the controlled slice.

Verification
REQ-030 len=3, back-to-back pairs (2,3),(4,5),(6,7) -> out_data=68, out_valid 3 cycles after third beat.
REQ-031 Same job with in_valid low 1-4 random cycles between beats -> out_data=68, no extra accumulation.
REQ-032 Result ready, out_ready low 10 cycles, start pulsed meanwhile -> out_valid/out_data=68 held, start ignored, busy=1.
REQ-033 len=255, all operands 18'h3FFFF -> out_data=17523332874495.
REQ-034 RST asserted after 2 beats of len=4 job -> busy=0, in_ready=0 immediately; then len=1, pair (5,5) -> out_data=25.
REQ-035 start with len=0 -> busy stays 0, no dsp_CE* pulses, no out_valid.

Source files
------------

// File: rtl/dsp_mac_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer_pkg
//   Shared definitions for the MAC sequencer that drives a DSP48A1-style slice.
//   - state_e        : sequencer FSM states
//   - OPMODE_MAC_DEF : slice opcode X=M, Z=P, add, no pre-adder, carry-in 0
//   - CEM_DLY/CEP_DLY: beat-to-clock-enable latency of the slice M and P regs
// -----------------------------------------------------------------------------
package dsp_mac_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [7:0] OPMODE_MAC_DEF = 8'b0000_1001;

    // A1/B1 register the operands on the beat edge, so M is written one
    // cycle after the beat and P one cycle after that.
    localparam int CEM_DLY = 1;
    localparam int CEP_DLY = 2;

endpackage

// File: rtl/dsp_mac_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_mac_sequencer
//   Streams LEN operand pairs into an external DSP48A1-style slice configured
//   as an unsigned multiply-accumulator and presents the 48-bit sum once.
//
//   Ports
//     CLK, RST              clock, async active-high reset
//     start, len            job request / pair count (sampled in IDLE)
//     busy                  high whenever not IDLE
//     in_valid/in_ready     operand stream handshake, in_a/in_b operands
//     out_valid/out_ready   result handshake, out_data = accumulated sum
//     dsp_*                 slice data, opcode, clock enables, resets, dsp_P
// -----------------------------------------------------------------------------
module dsp_mac_sequencer
    import dsp_mac_sequencer_pkg::*;
#(
    parameter int         LEN_W      = 8,
    parameter logic [7:0] OPMODE_MAC = OPMODE_MAC_DEF
) (
    input  logic             CLK,
    input  logic             RST,

    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [47:0]      out_data,

    output logic [17:0]      dsp_A,
    output logic [17:0]      dsp_B,
    output logic [7:0]       dsp_OPMODE,
    output logic             dsp_CEA,
    output logic             dsp_CEB,
    output logic             dsp_CEM,
    output logic             dsp_CEP,
    output logic             dsp_CEOPMODE,
    output logic             dsp_RSTM,
    output logic             dsp_RSTP,
    input  logic [47:0]      dsp_P
);

    state_e             state_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [CEP_DLY-1:0] vld_q;      // beat history: bit i = beat i+1 cycles ago
    logic               busy_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               clr_q;

    logic               beat;
    logic               last_beat;

    // in_ready is registered and independent of in_valid, so beat is a
    // single AND with no combinational loop back to the source.
    assign beat      = in_valid & in_ready_q;
    assign last_beat = beat && (cnt_q == LEN_W'(1));

    // Single FSM with registered status/control outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (len != '0)) begin
                        cnt_q   <= len;
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        clr_q   <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_q      <= 1'b0;
                    in_ready_q <= 1'b1;
                    state_q    <= ST_FEED;
                end
                ST_FEED: begin
                    if (beat) begin
                        cnt_q <= cnt_q - LEN_W'(1);
                        if (last_beat) begin
                            in_ready_q <= 1'b0;
                            state_q    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // No beats arrive here, so once the newest history bit is
                    // clear the pipe is empty on the next edge and P is final.
                    if (!vld_q[0]) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    clr_q       <= 1'b0;
                end
            endcase
        end
    end

    // Beat valid shift register mirroring the slice M/P register latency.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) vld_q <= '0;
        else     vld_q <= {vld_q[CEP_DLY-2:0], beat};
    end

    assign busy         = busy_q;
    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    // P is frozen in DONE (CEP low), so it is passed straight through.
    assign out_data     = dsp_P;

    assign dsp_A        = beat ? in_a : 18'd0;
    assign dsp_B        = beat ? in_b : 18'd0;
    assign dsp_CEA      = beat;
    assign dsp_CEB      = beat;
    assign dsp_CEM      = vld_q[CEM_DLY-1];
    assign dsp_CEP      = vld_q[CEP_DLY-1];
    assign dsp_OPMODE   = OPMODE_MAC;
    assign dsp_CEOPMODE = 1'b1;
    assign dsp_RSTM     = clr_q;
    assign dsp_RSTP     = clr_q;

endmodule
